// File: rtl/mdu_issue_ctrl.sv
// Issue sequencer between EX and the shared multi-cycle multiplier/divider.
// Optional MDU_FUSE_EN: reuse the last divide result when DIV and REM share operands.
module mdu_issue_ctrl #(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            req_valid,
  input  logic [4:0]      req_op,
  input  logic            req_w,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            resp_ready,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_data,
  output logic            stall_o,
  output logic            err_timeout,
  output logic            mul_valid,
  output logic            div_valid,
  output logic            mul_flush,
  output logic            div_flush,
  output logic            mulw,
  output logic            divw,
  output logic [1:0]      mul_signed,
  output logic            div_signed,
  output logic [XLEN-1:0] op_a,
  output logic [XLEN-1:0] op_b,
  input  logic            mul_ready,
  input  logic            div_ready,
  input  logic            mul_out_valid,
  input  logic            div_out_valid,
  input  logic [XLEN-1:0] result_hi,
  input  logic [XLEN-1:0] result_lo,
  input  logic [XLEN-1:0] quotient,
  input  logic [XLEN-1:0] remainder
);

  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StBusy, StDone} state_e;

  state_e            state_q;
  logic [4:0]        op_q;
  logic              w_q;
  logic [XLEN-1:0]   a_q;
  logic [XLEN-1:0]   b_q;
  logic [CntW-1:0]   cnt_q;

  logic              req_md;
  logic              x_ready;
  logic              x_out_valid;
  logic [XLEN-1:0]   raw_result;
  logic [XLEN-1:0]   cur_result;
  logic              fuse_hit;
  logic [XLEN-1:0]   fuse_result;

  function automatic logic [XLEN-1:0] wext(input logic [XLEN-1:0] r, input logic w);
    return w ? {{(XLEN-32){r[31]}}, r[31:0]} : r;
  endfunction

  assign req_md      = req_valid & req_op[4];
  assign x_ready     = op_q[3] ? div_ready : mul_ready;
  assign x_out_valid = op_q[3] ? div_out_valid : mul_out_valid;

  always_comb begin
    raw_result = '0;
    if (op_q[3]) raw_result = op_q[1] ? remainder : quotient;
    else         raw_result = op_q[2] ? result_hi : result_lo;
    cur_result = wext(raw_result, w_q);
  end

  assign stall_o    = req_md & ~(resp_valid & resp_ready);
  assign mulw       = w_q;
  assign divw       = w_q;
  assign mul_signed = op_q[1:0];
  assign div_signed = op_q[0];
  assign op_a       = a_q;
  assign op_b       = b_q;

`ifdef MDU_FUSE_EN
  logic            tag_valid_q;
  logic [XLEN-1:0] tag_a_q;
  logic [XLEN-1:0] tag_b_q;
  logic            tag_w_q;
  logic            tag_s_q;
  logic [XLEN-1:0] quot_q;
  logic [XLEN-1:0] rem_q;

  assign fuse_hit = req_op[3] & tag_valid_q & (src1 == tag_a_q) & (src2 == tag_b_q) &
                    (req_w == tag_w_q) & (req_op[0] == tag_s_q);
  assign fuse_result = wext(req_op[1] ? rem_q : quot_q, req_w);

  // Tag survives flush: a stored quotient/remainder pair stays correct for its operands.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_valid_q <= 1'b0;
      tag_a_q     <= '0;
      tag_b_q     <= '0;
      tag_w_q     <= 1'b0;
      tag_s_q     <= 1'b0;
      quot_q      <= '0;
      rem_q       <= '0;
    end else if (!flush && state_q == StBusy && op_q[3] && div_out_valid) begin
      tag_valid_q <= 1'b1;
      tag_a_q     <= a_q;
      tag_b_q     <= b_q;
      tag_w_q     <= w_q;
      tag_s_q     <= op_q[0];
      quot_q      <= quotient;
      rem_q       <= remainder;
    end
  end
`else
  assign fuse_hit    = 1'b0;
  assign fuse_result = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      op_q        <= '0;
      w_q         <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      cnt_q       <= '0;
      resp_valid  <= 1'b0;
      resp_data   <= '0;
      err_timeout <= 1'b0;
      mul_valid   <= 1'b0;
      div_valid   <= 1'b0;
      mul_flush   <= 1'b0;
      div_flush   <= 1'b0;
    end else begin
      mul_flush <= 1'b0;
      div_flush <= 1'b0;
      if (flush) begin
        // Flush beats everything, including a same-cycle unit result or new request.
        if (state_q == StIssue || state_q == StBusy) begin
          mul_flush <= ~op_q[3];
          div_flush <= op_q[3];
        end
        mul_valid  <= 1'b0;
        div_valid  <= 1'b0;
        resp_valid <= 1'b0;
        state_q    <= StIdle;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (req_md) begin
              op_q <= req_op;
              w_q  <= req_w;
              a_q  <= src1;
              b_q  <= src2;
              if (fuse_hit) begin
                resp_data  <= fuse_result;
                resp_valid <= 1'b1;
                state_q    <= StDone;
              end else begin
                mul_valid <= ~req_op[3];
                div_valid <= req_op[3];
                state_q   <= StIssue;
              end
            end
          end
          StIssue: begin
            if (x_ready) begin
              mul_valid <= 1'b0;
              div_valid <= 1'b0;
              cnt_q     <= '0;
              state_q   <= StBusy;
            end
          end
          StBusy: begin
            if (x_out_valid) begin
              resp_data  <= cur_result;
              resp_valid <= 1'b1;
              state_q    <= StDone;
            end else if (cnt_q == CntW'(TIMEOUT)) begin
              err_timeout <= 1'b1;
              mul_flush   <= ~op_q[3];
              div_flush   <= op_q[3];
              state_q     <= StIdle;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          StDone: begin
            if (resp_ready) begin
              resp_valid <= 1'b0;
              state_q    <= StIdle;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Directed bench for mdu_issue_ctrl: table of MD ops against a stub mul/div unit,
// plus hand sequences for back-pressure, flush, timeout and (MDU_FUSE_EN) fused REM.
module tb_mdu_issue_ctrl;

  localparam int unsigned XLEN    = 64;
  localparam int unsigned TIMEOUT = 255;
`ifdef MDU_FUSE_EN
  localparam bit FuseEn = 1'b1;
`else
  localparam bit FuseEn = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst, flush, req_valid, req_w, resp_ready;
  logic [4:0]      req_op;
  logic [XLEN-1:0] src1, src2;
  logic            resp_valid, stall_o, err_timeout;
  logic [XLEN-1:0] resp_data, op_a, op_b;
  logic            mul_valid, div_valid, mul_flush, div_flush, mulw, divw, div_signed;
  logic [1:0]      mul_signed;
  logic            mul_ready, div_ready, mul_out_valid, div_out_valid;
  logic [XLEN-1:0] result_hi, result_lo, quotient, remainder;

  mdu_issue_ctrl #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid), .req_op(req_op),
    .req_w(req_w), .src1(src1), .src2(src2), .resp_ready(resp_ready),
    .resp_valid(resp_valid), .resp_data(resp_data), .stall_o(stall_o),
    .err_timeout(err_timeout), .mul_valid(mul_valid), .div_valid(div_valid),
    .mul_flush(mul_flush), .div_flush(div_flush), .mulw(mulw), .divw(divw),
    .mul_signed(mul_signed), .div_signed(div_signed), .op_a(op_a), .op_b(op_b),
    .mul_ready(mul_ready), .div_ready(div_ready), .mul_out_valid(mul_out_valid),
    .div_out_valid(div_out_valid), .result_hi(result_hi), .result_lo(result_lo),
    .quotient(quotient), .remainder(remainder)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Stub unit: counts handshakes and answers unit_lat cycles later unless hung.
  int mul_hs = 0;
  int div_hs = 0;
  int unit_lat = 3;
  bit stub_hang = 1'b0;
  int pend = 0;
  bit pend_div = 1'b0;

  initial begin
    mul_out_valid = 1'b0;
    div_out_valid = 1'b0;
    forever begin
      @(negedge clk);
      mul_out_valid = 1'b0;
      div_out_valid = 1'b0;
      if (rst || mul_flush || div_flush) pend = 0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          if (pend_div) div_out_valid = 1'b1;
          else          mul_out_valid = 1'b1;
        end
      end
      if (mul_valid && mul_ready) begin
        mul_hs++;
        pend     = stub_hang ? 0 : unit_lat;
        pend_div = 1'b0;
      end
      if (div_valid && div_ready) begin
        div_hs++;
        pend     = stub_hang ? 0 : unit_lat;
        pend_div = 1'b1;
      end
    end
  end

  typedef struct {
    string       name;
    logic [4:0]  op;
    logic        w;
    logic [63:0] s1, s2, hi, lo, q, r, expv;
    bit          fusable;
  } vec_t;

  function automatic vec_t mk(input string n, input logic [4:0] op, input logic w,
                              input logic [63:0] s1, input logic [63:0] s2,
                              input logic [63:0] hi, input logic [63:0] lo,
                              input logic [63:0] q, input logic [63:0] r,
                              input logic [63:0] e, input bit f);
    vec_t v;
    v.name = n; v.op = op; v.w = w; v.s1 = s1; v.s2 = s2; v.hi = hi; v.lo = lo;
    v.q = q; v.r = r; v.expv = e; v.fusable = f;
    return v;
  endfunction

  // Issue one op with resp_ready high; checks result, handshakes, stall and latched fields.
  task automatic run_op(input vec_t v, output int lat);
    bit stall_bad;
    bit got;
    result_hi = v.hi; result_lo = v.lo; quotient = v.q; remainder = v.r;
    mul_hs = 0; div_hs = 0; stall_bad = 1'b0; got = 1'b0; lat = 0;
    req_valid = 1'b1; req_op = v.op; req_w = v.w; src1 = v.s1; src2 = v.s2;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (resp_valid) begin
        got = 1'b1;
        lat = i;
        break;
      end
      if (!stall_o) stall_bad = 1'b1;
    end
    chk({v.name, " resp_valid"}, 64'(got), 64'd1);
    chk({v.name, " resp_data"}, resp_data, v.expv);
    chk({v.name, " stall_before_resp"}, 64'(stall_bad), 64'd0);
    chk({v.name, " stall_at_handshake"}, 64'(stall_o), 64'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk({v.name, " resp_valid_drop"}, 64'(resp_valid), 64'd0);
    chk({v.name, " mul_hs"}, 64'(mul_hs), v.op[3] ? 64'd0 : 64'd1);
    chk({v.name, " div_hs"}, 64'(div_hs),
        (v.op[3] && !(FuseEn && v.fusable)) ? 64'd1 : 64'd0);
    chk({v.name, " w_latched"}, 64'({mulw, divw}), v.w ? 64'd3 : 64'd0);
    if (v.op[3]) chk({v.name, " div_signed"}, 64'(div_signed), 64'(v.op[0]));
    else         chk({v.name, " mul_signed"}, 64'(mul_signed), 64'(v.op[1:0]));
  endtask

  vec_t vecs[9];
  int   lat;
  bit   seen;
  int   n;

  initial begin
    vecs[0] = mk("MUL 3*5", 5'b10011, 1'b0, 64'd3, 64'd5, 64'd0, 64'd15, 0, 0, 64'd15, 0);
    vecs[1] = mk("MULHU", 5'b10100, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1,
                 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 64'd1, 0);
    vecs[2] = mk("MULH -3*4", 5'b10111, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd4,
                 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF4, 0, 0,
                 64'hFFFF_FFFF_FFFF_FFFF, 0);
    vecs[3] = mk("MULW", 5'b10011, 1'b1, 64'h7FFF_FFFF, 64'd2, 64'd0, 64'hFFFF_FFFE, 0, 0,
                 64'hFFFF_FFFF_FFFF_FFFE, 0);
    vecs[4] = mk("DIVW -7/2", 5'b11001, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 0, 0,
                 64'h0000_0000_FFFF_FFFD, 64'h0000_0000_FFFF_FFFF,
                 64'hFFFF_FFFF_FFFF_FFFD, 0);
    vecs[5] = mk("REMW -7/2", 5'b11011, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 0, 0,
                 64'h0000_0000_FFFF_FFFD, 64'h0000_0000_FFFF_FFFF,
                 64'hFFFF_FFFF_FFFF_FFFF, 1);
    vecs[6] = mk("DIVU 100/7", 5'b11000, 1'b0, 64'd100, 64'd7, 0, 0, 64'd14, 64'd2, 64'd14, 0);
    vecs[7] = mk("REMU 100/7", 5'b11010, 1'b0, 64'd100, 64'd7, 0, 0, 64'd14, 64'd2, 64'd2, 1);
    vecs[8] = mk("DIVU 5/0", 5'b11000, 1'b0, 64'd5, 64'd0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF,
                 64'd5, 64'hFFFF_FFFF_FFFF_FFFF, 0);

    rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_op = '0; req_w = 1'b0;
    src1 = '0; src2 = '0; resp_ready = 1'b1; mul_ready = 1'b1; div_ready = 1'b1;
    result_hi = '0; result_lo = '0; quotient = '0; remainder = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset ctrl", 64'({resp_valid, mul_valid, div_valid, mul_flush, div_flush,
                           err_timeout, stall_o}), 64'd0);
    chk("reset data", resp_data | op_a | op_b, 64'd0);

    // Non-MD op is ignored and never stalls.
    req_valid = 1'b1; req_op = 5'b00011;
    @(posedge clk); #1;
    chk("nonmd stall", 64'(stall_o), 64'd0);
    @(posedge clk); #1;
    chk("nonmd issue", 64'({mul_valid, div_valid}), 64'd0);
    req_valid = 1'b0;

    foreach (vecs[i]) run_op(vecs[i], lat);

    // Request coincident with flush must not be accepted.
    req_valid = 1'b1; req_op = 5'b10011; flush = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b0;
    chk("req_with_flush", 64'({mul_valid, div_valid}), 64'd0);

    // Back-pressure: DONE held four cycles.
    resp_ready = 1'b0; result_lo = 64'd81; result_hi = '0; mul_hs = 0;
    req_valid = 1'b1; req_op = 5'b10011; req_w = 1'b0; src1 = 64'd9; src2 = 64'd9;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (resp_valid) begin seen = 1'b1; break; end
    end
    chk("bp resp_valid", 64'(seen), 64'd1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("bp hold", {resp_valid, stall_o, resp_data[61:0]}, {2'b11, 62'd81});
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("bp release", 64'(resp_valid), 64'd0);
    repeat (2) @(posedge clk); #1;
    chk("bp single handshake", 64'({resp_valid, mul_valid, 30'd0} | 64'(mul_hs)), 64'd1);

    // Flush three cycles into BUSY on a divide.
    unit_lat = 20; div_hs = 0;
    req_valid = 1'b1; req_op = 5'b11000; src1 = 64'd50; src2 = 64'd3;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (div_hs == 1 && !div_valid) begin seen = 1'b1; break; end
    end
    chk("flush div handshake", 64'(seen), 64'd1);
    repeat (3) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; req_valid = 1'b0;
    chk("flush div_flush pulse", 64'({div_flush, mul_flush}), 64'b10);
    @(posedge clk); #1;
    chk("flush div_flush drop", 64'(div_flush), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (resp_valid) seen = 1'b1;
    end
    chk("flush no resp", 64'(seen), 64'd0);
    unit_lat = 3;
    run_op(mk("MUL 6*7", 5'b10011, 1'b0, 64'd6, 64'd7, 0, 64'd42, 0, 0, 64'd42, 0), lat);

    // Hung multiplier: timeout sets sticky error and flushes.
    stub_hang = 1'b1; mul_hs = 0;
    req_valid = 1'b1; req_op = 5'b10011; src1 = 64'd2; src2 = 64'd2;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (mul_hs == 1 && !mul_valid) begin seen = 1'b1; break; end
    end
    chk("timeout handshake", 64'(seen), 64'd1);
    n = 0;
    for (int i = 1; i <= 400; i++) begin
      @(posedge clk); #1;
      if (mul_flush) begin n = i; break; end
      if (err_timeout) begin n = -i; break; end
    end
    req_valid = 1'b0; stub_hang = 1'b0;
    chk("timeout cycles in range", 64'(n >= int'(TIMEOUT) && n <= int'(TIMEOUT) + 1), 64'd1);
    chk("timeout err", 64'({err_timeout, resp_valid}), 64'b10);
    @(posedge clk); #1;
    chk("timeout idle", 64'({mul_flush, mul_valid, resp_valid}), 64'd0);
    run_op(mk("MUL after timeout", 5'b10011, 1'b0, 64'd6, 64'd7, 0, 64'd42, 0, 0, 64'd42, 0),
           lat);
    chk("err sticky", 64'(err_timeout), 64'd1);

`ifdef MDU_FUSE_EN
    run_op(mk("DIVU 17/5", 5'b11000, 1'b0, 64'd17, 64'd5, 0, 0, 64'd3, 64'd2, 64'd3, 0), lat);
    // Stub values changed so a wrongly issued REM would return the wrong value.
    run_op(mk("REMU 17/5 fused", 5'b11010, 1'b0, 64'd17, 64'd5, 0, 0, 64'd99, 64'd99,
              64'd2, 1), lat);
    chk("fused latency", 64'(lat), 64'd1);
`endif

    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("reset clears err", 64'({err_timeout, resp_valid}), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
